// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen
//
// Built-in self-test wrapper for a small combinational circuit-under-test.
// An on-chip Galois LFSR drives the CUT pattern bus. A MISR compacts the CUT
// response bus into a signature, and that signature is compared against a
// golden value.
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start after reset; lfsr/sig/cnt hold
//   ST_RUN   | one pattern applied and one response absorbed per cycle
//   ST_DONE  | run complete; signature valid and held until the next start
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset (aborts a run)
//   start      in   1      begin a run; sampled only in IDLE or DONE
//   golden     in   SIG_W  expected fault-free signature
//   pattin     out  PAT_W  pattern to the CUT (low bits of the LFSR)
//   pattout    in   RSP_W  CUT response, combinational from pattin
//   busy       out  1      high while running
//   done       out  1      high while the signature is final
//   signature  out  SIG_W  MISR contents
//   pass       out  1      done and signature matches golden

module bist_pattern_gen #(
  parameter int                 PAT_W     = 2,
  parameter int                 RSP_W     = 1,
  parameter int                 LFSR_W    = 8,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = 8'h1D,
  parameter logic [LFSR_W-1:0]  SEED      = 8'h01,
  parameter int                 SIG_W     = 16,
  parameter logic [SIG_W-1:0]   MISR_POLY = 16'h1021,
  parameter int                 NUM_PATS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] golden,
  output logic [PAT_W-1:0] pattin,
  input  logic [RSP_W-1:0] pattout,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             pass
);

  localparam int              CNT_W    = $clog2(NUM_PATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [SIG_W-1:0]  r_sig;
  logic [SIG_W-1:0]  w_sig_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // An all-zero LFSR would never leave zero, so it is reseeded instead.
  always_comb begin
    if (r_lfsr == '0) begin
      w_lfsr_nxt = SEED;
    end else begin
      w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], 1'b0} ^ (r_lfsr[LFSR_W-1] ? LFSR_TAPS : '0);
    end
  end

  always_comb begin
    w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
              ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
              ^ SIG_W'(pattout);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= SEED;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_lfsr <= SEED;
        r_sig  <= '0;
        r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
        r_lfsr <= w_lfsr_nxt;
        r_sig  <= w_sig_nxt;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign pattin    = r_lfsr[PAT_W-1:0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;
  assign pass      = r_done && (r_sig == golden);

endmodule
